wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 41 ++++
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back port bundle: pipeline and long-latency result inputs plus the register-file write port.
// Adds the decode pending-lookup signals when WB_PENDING_EN is defined.
interface wb_arbiter_if;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wd;
  logic [31:0] lu_wdata;
  logic        we;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        stall_req;
`ifdef WB_PENDING_EN
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        pend1;
  logic        pend2;
`endif

  // Arbiter side
  modport slave (
    input  mem_wreg, mem_wd, mem_wdata, lu_valid, lu_wd, lu_wdata,
`ifdef WB_PENDING_EN
    input  rd_addr1, rd_addr2,
    output pend1, pend2,
`endif
    output lu_ready, we, writeAddr, writeData, stall_req
  );

  // Pipeline / long-latency unit / register-file side
  modport master (
    output mem_wreg, mem_wd, mem_wdata, lu_valid, lu_wd, lu_wdata,
`ifdef WB_PENDING_EN
    output rd_addr1, rd_addr2,
    input  pend1, pend2,
`endif
    input  lu_ready, we, writeAddr, writeData, stall_req
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results queue in a 2-entry FIFO.
// Optional WB_PENDING_EN adds combinational pending-hazard lookups for two decode read ports.
module wb_arbiter #(
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  logic [AW-1:0]    ent_addr   [DEPTH];
  logic [DW-1:0]    ent_data   [DEPTH];
  logic [AW-1:0]    ent_addr_n [DEPTH];
  logic [DW-1:0]    ent_data_n [DEPTH];
  logic [DEPTH-1:0] vld, vld_n;
  logic [PW-1:0]    rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [CW-1:0]    count, count_n;
  logic [SW-1:0]    starve, starve_n;
  logic             we_q, we_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic [DW-1:0]    data_q, data_n;

  logic pipe_eff, lu_rdy, lu_acc, lu_push, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ent_addr <= ent_addr_n;
      ent_data <= ent_data_n;
      vld      <= vld_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      count    <= count_n;
      starve   <= starve_n;
      we_q     <= we_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
    end
  end

  always_comb begin
    ent_addr_n = ent_addr;
    ent_data_n = ent_data;
    vld_n      = vld;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    we_n       = 1'b0;
    addr_n     = addr_q;
    data_n     = data_q;
    starve_n   = starve;

    pipe_eff = bus.mem_wreg && (bus.mem_wd != AW'(0));
    lu_rdy   = (count < CW'(DEPTH));
    lu_acc   = bus.lu_valid && lu_rdy;
    lu_push  = lu_acc && (bus.lu_wd != AW'(0));
    pop      = !pipe_eff && (count != CW'(0));

    if (pipe_eff) begin
      we_n   = 1'b1;
      addr_n = bus.mem_wd;
      data_n = bus.mem_wdata;
      // Younger pipeline write supersedes any buffered result to the same register
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (vld[i] && (ent_addr[i] == bus.mem_wd)) vld_n[i] = 1'b0;
      end
    end else if (pop) begin
      we_n = vld[rd_ptr];
      if (vld[rd_ptr]) begin
        addr_n = ent_addr[rd_ptr];
        data_n = ent_data[rd_ptr];
      end
      vld_n[rd_ptr] = 1'b0;
      rd_ptr_n      = rd_ptr + PW'(1);
    end

    // Push after invalidation so a same-cycle entry to mem_wd survives
    if (lu_push) begin
      vld_n[wr_ptr]      = 1'b1;
      ent_addr_n[wr_ptr] = bus.lu_wd;
      ent_data_n[wr_ptr] = bus.lu_wdata;
      wr_ptr_n           = wr_ptr + PW'(1);
    end

    count_n = count + CW'(lu_push) - CW'(pop);

    if (pop || (vld == '0)) starve_n = '0;
    else if (starve != SW'(STARVE_LIM)) starve_n = starve + SW'(1);
  end

  assign bus.lu_ready  = lu_rdy;
  assign bus.stall_req = (starve == SW'(STARVE_LIM));
  assign bus.we        = we_q;
  assign bus.writeAddr = addr_q;
  assign bus.writeData = data_q;

`ifdef WB_PENDING_EN
  logic pend1_c, pend2_c;

  // A register is pending if a live FIFO entry or this cycle's accepted lu result targets it
  function automatic logic is_pending(input logic [AW-1:0] ra);
    logic hit;
    hit = lu_acc && (bus.lu_wd == ra);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ent_addr[i] == ra)) hit = 1'b1;
    end
    return hit && (ra != AW'(0));
  endfunction

  always_comb begin
    pend1_c = is_pending(bus.rd_addr1);
    pend2_c = is_pending(bus.rd_addr2);
  end

  assign bus.pend1 = pend1_c;
  assign bus.pend2 = pend2_c;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: pipe path, lu path, backpressure/starvation, kill, r0, reset.
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_LIM(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic en, input logic [4:0] wd, input logic [31:0] d);
    bus.mem_wreg  = en;
    bus.mem_wd    = wd;
    bus.mem_wdata = d;
  endtask

  task automatic lu(input logic en, input logic [4:0] wd, input logic [31:0] d);
    bus.lu_valid = en;
    bus.lu_wd    = wd;
    bus.lu_wdata = d;
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"},   32'(bus.we), 32'(w));
    chk({tag, "_addr"}, 32'(bus.writeAddr), 32'(a));
    chk({tag, "_data"}, bus.writeData, d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
`ifdef WB_PENDING_EN
    bus.rd_addr1 = 5'd0;
    bus.rd_addr2 = 5'd0;
`endif

    // Reset state
    #2;
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_ready", 32'(bus.lu_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_we", 32'(bus.we), 32'd0);

    // Pipe-only write: latency 1, then idle holds addr/data
    pipe(1'b1, 5'd5, 32'h1234);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    chk_wr("pipe_t1", 1'b1, 5'd5, 32'h1234);
    tick();
    chk_wr("pipe_t2", 1'b0, 5'd5, 32'h1234);

    // Idle lu result: never bypassed, written at t+2
    lu(1'b1, 5'd7, 32'hAA);
    chk("lu_ready_t", 32'(bus.lu_ready), 32'd1);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    chk("lu_t1_we", 32'(bus.we), 32'd0);
    tick();
    chk_wr("lu_t2", 1'b1, 5'd7, 32'hAA);
    tick();
    chk("lu_t3_we", 32'(bus.we), 32'd0);

    // Register 0: pipe write ignored, lu handshake consumed without buffering
    pipe(1'b1, 5'd0, 32'hFF);
    lu(1'b1, 5'd0, 32'hEE);
    chk("r0_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    chk("r0_t1_we", 32'(bus.we), 32'd0);
    chk("r0_t1_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    chk("r0_t2_we", 32'(bus.we), 32'd0);

    // Kill: buffered r4 superseded by pipeline write, stale entry popped with we=0
    lu(1'b1, 5'd4, 32'h11);
    tick();
    lu(1'b0, 5'd0, 32'h0);
`ifdef WB_PENDING_EN
    bus.rd_addr1 = 5'd4;
    bus.rd_addr2 = 5'd6;
    #1;
    chk("pend1_hit", 32'(bus.pend1), 32'd1);
    chk("pend2_miss", 32'(bus.pend2), 32'd0);
    bus.rd_addr1 = 5'd0;
    bus.rd_addr2 = 5'd0;
`endif
    pipe(1'b1, 5'd4, 32'h22);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    chk_wr("kill_t1", 1'b1, 5'd4, 32'h22);
    tick();
    chk_wr("kill_pop", 1'b0, 5'd4, 32'h22);
    tick();
    chk("kill_idle_we", 32'(bus.we), 32'd0);

    // Backpressure and starvation under continuous pipe writes to r3
    pipe(1'b1, 5'd3, 32'h33);
    lu(1'b1, 5'd8, 32'h88);
    chk("bp_ready0", 32'(bus.lu_ready), 32'd1);
    tick();
    chk_wr("bp_pipe", 1'b1, 5'd3, 32'h33);
    lu(1'b1, 5'd9, 32'h99);
    chk("bp_ready1", 32'(bus.lu_ready), 32'd1);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    chk("bp_full", 32'(bus.lu_ready), 32'd0);
    chk("bp_stall_c1", 32'(bus.stall_req), 32'd0);
    for (int i = 2; i < 8; i++) begin
      tick();
      chk($sformatf("bp_stall_c%0d", i), 32'(bus.stall_req), 32'd0);
    end
    tick();
    chk("bp_stall_c8", 32'(bus.stall_req), 32'd1);
    tick();
    chk("bp_stall_sat", 32'(bus.stall_req), 32'd1);
    chk("bp_full_sat", 32'(bus.lu_ready), 32'd0);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_wr("bp_drain8", 1'b1, 5'd8, 32'h88);
    chk("bp_stall_clr", 32'(bus.stall_req), 32'd0);
    chk("bp_ready_back", 32'(bus.lu_ready), 32'd1);
    tick();
    chk_wr("bp_drain9", 1'b1, 5'd9, 32'h99);
    tick();
    chk("bp_idle_we", 32'(bus.we), 32'd0);

    // Asynchronous reset with a full FIFO discards buffered results
    pipe(1'b1, 5'd2, 32'h2);
    lu(1'b1, 5'd12, 32'hC);
    tick();
    lu(1'b1, 5'd13, 32'hD);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    chk("ar_full", 32'(bus.lu_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_we", 32'(bus.we), 32'd0);
    chk("ar_ready", 32'(bus.lu_ready), 32'd1);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_after%0d", i), 32'(bus.we), 32'd0);
    end
    chk("ar_stall", 32'(bus.stall_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
